// File: rtl/pkg_alu.sv
// Shared ALU-path types: state encoding for the Nack-aware send unit.
package pkg_alu;

   typedef enum logic [1:0] {
      sIDLE_S = 2'd0,
      sSEND_S = 2'd1,
      sHOLD_S = 2'd2
   } fsm_send;

endpackage

// File: rtl/nack_send_buffer.sv
// DEPTH x WIDTH_DATA ring buffer; occupancy is counted separately so full and empty never alias.
module nack_send_buffer #(
   parameter int WIDTH_DATA = 32,
   parameter int DEPTH      = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH_DATA-1:0]  wr_data,
   input  logic                   rd_en,
   output logic [WIDTH_DATA-1:0]  rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH_DATA-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/nack_send_unit.sv
// Source-side Nack-token sender: buffers producer words and re-presents the head until accepted.
module nack_send_unit
   import pkg_alu::*;
#(
   parameter int WIDTH_DATA = 32,
   parameter int DEPTH      = 4,
   parameter int NACK_LIMIT = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   I_Active,
   input  logic                   I_Valid,
   input  logic [WIDTH_DATA-1:0]  I_Data,
   output logic                   O_Nack,
   output logic                   O_Valid,
   output logic [WIDTH_DATA-1:0]  O_Data,
   input  logic                   I_Nack,
   input  logic                   I_Rls,
   output logic                   O_Stall,
   output logic [$clog2(DEPTH):0] O_Count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int NW = $clog2(NACK_LIMIT + 1);

   fsm_send               state, state_next;
   logic [NW-1:0]         nack_cnt, nack_next;
   logic [CW-1:0]         count, count_next;
   logic [WIDTH_DATA-1:0] head;
   logic                  full, empty;
   logic                  enq, deq, nacked;

   function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] v);
      return (v == NW'(NACK_LIMIT)) ? v : v + NW'(1);
   endfunction

   nack_send_buffer #(
      .WIDTH_DATA (WIDTH_DATA),
      .DEPTH      (DEPTH)
   ) u_buf (
      .clock   (clock),
      .reset   (reset),
      .flush   (I_Rls),
      .wr_en   (enq),
      .wr_data (I_Data),
      .rd_en   (deq),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Token gating: O_Nack depends only on flops and I_Active, never on I_Nack.
   assign O_Nack  = ~I_Active | full;
   assign O_Valid = I_Active & ~empty;
   assign O_Data  = O_Valid ? head : '0;
   assign O_Count = count;

   assign enq    = I_Valid & ~O_Nack & ~I_Rls;
   assign deq    = O_Valid & ~I_Nack & ~I_Rls;
   assign nacked = O_Valid &  I_Nack & ~I_Rls;

   always_comb begin
      count_next = count;
      case ({enq, deq})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_comb begin
      state_next = state;
      nack_next  = nack_cnt;
      if (I_Rls) begin
         state_next = sIDLE_S;
         nack_next  = '0;
      end else if (I_Active) begin
         case (state)
            sIDLE_S: begin
               nack_next = '0;
               if (enq)
                  state_next = sSEND_S;
            end
            sSEND_S, sHOLD_S: begin
               if (deq) begin
                  state_next = (count_next == '0) ? sIDLE_S : sSEND_S;
                  nack_next  = '0;
               end else if (nacked) begin
                  state_next = sHOLD_S;
                  nack_next  = sat_inc(nack_cnt);
               end
            end
            default: begin
               state_next = sIDLE_S;
               nack_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= sIDLE_S;
         nack_cnt <= '0;
         O_Stall  <= 1'b0;
      end else begin
         state    <= state_next;
         nack_cnt <= nack_next;
         O_Stall  <= (nack_next == NW'(NACK_LIMIT));
      end
   end

endmodule

// File: tb/tb_nack_send_unit.sv
// Bench for nack_send_unit: vector table, directed corner sequences, randomized queue model.
module tb_nack_send_unit;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int L  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          I_Active = 1'b0;
   logic          I_Valid = 1'b0;
   logic [W-1:0]  I_Data = '0;
   logic          I_Nack = 1'b0;
   logic          I_Rls = 1'b0;
   logic          O_Nack, O_Valid, O_Stall;
   logic [W-1:0]  O_Data;
   logic [CW-1:0] O_Count;

   always #5 clock = ~clock;

   nack_send_unit #(.WIDTH_DATA(W), .DEPTH(D), .NACK_LIMIT(L)) dut (
      .clock(clock), .reset(reset), .I_Active(I_Active), .I_Valid(I_Valid),
      .I_Data(I_Data), .O_Nack(O_Nack), .O_Valid(O_Valid), .O_Data(O_Data),
      .I_Nack(I_Nack), .I_Rls(I_Rls), .O_Stall(O_Stall), .O_Count(O_Count)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [W-1:0]  q[$];
   int            streak = 0;
   logic [W-1:0]  dut_out[$];
   logic          s_nack, s_valid, s_stall;
   logic [W-1:0]  s_data;
   logic [CW-1:0] s_count;

   typedef struct {
      logic          act, vld;
      logic [W-1:0]  d;
      logic          nck;
      logic          e_valid;
      logic [W-1:0]  e_data;
      logic [CW-1:0] e_count;
      logic          e_nack;
   } vec_t;
   vec_t tbl[11];

   task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive, sample mid-cycle, check against the queue model, advance the model.
   task automatic cycle(input logic act, input logic vld, input logic [W-1:0] d,
                        input logic nck, input logic rls);
      logic         e_nack, e_valid, enq, deq;
      logic [W-1:0] e_data;
      I_Active = act; I_Valid = vld; I_Data = d; I_Nack = nck; I_Rls = rls;
      #2;
      s_nack = O_Nack; s_valid = O_Valid; s_data = O_Data;
      s_count = O_Count; s_stall = O_Stall;
      e_nack  = !act || (q.size() == D);
      e_valid = act && (q.size() != 0);
      e_data  = e_valid ? q[0] : '0;
      cmp("m_nack",  W'(s_nack),  W'(e_nack));
      cmp("m_valid", W'(s_valid), W'(e_valid));
      cmp("m_data",  s_data,      e_data);
      cmp("m_count", W'(s_count), W'(q.size()));
      cmp("m_stall", W'(s_stall), W'(streak == L));
      if (s_valid && !nck && !rls)
         dut_out.push_back(s_data);
      enq = vld && !e_nack && !rls;
      deq = e_valid && !nck && !rls;
      if (rls) begin
         q.delete();
         streak = 0;
      end else begin
         if (deq) begin
            void'(q.pop_front());
            streak = 0;
         end else if (e_valid && nck) begin
            streak = (streak >= L) ? L : streak + 1;
         end
         if (enq)
            q.push_back(d);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [W-1:0] w[$];
      logic         st[16];
      int           i, budget;

      tbl[0]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 3'd1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 32'h22, 3'd1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h33, 3'd1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 32'hA5, 1'b1, 1'b0, 32'h00, 3'd0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 3'd1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 3'd1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 3'd1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'hA5, 3'd1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0};

      // Reset state, with I_Active both low and high.
      #3;
      cmp("rst_valid", W'(O_Valid), 0);
      cmp("rst_count", W'(O_Count), 0);
      cmp("rst_stall", W'(O_Stall), 0);
      cmp("rst_nack_inactive", W'(O_Nack), 1);
      I_Active = 1'b1;
      #1;
      cmp("rst_nack_active", W'(O_Nack), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Streaming and single-word Nack retention from the vector table.
      for (int k = 0; k < 11; k++) begin
         cycle(tbl[k].act, tbl[k].vld, tbl[k].d, tbl[k].nck, 1'b0);
         cmp($sformatf("tbl%0d_valid", k), W'(s_valid), W'(tbl[k].e_valid));
         cmp($sformatf("tbl%0d_data", k),  s_data,       tbl[k].e_data);
         cmp($sformatf("tbl%0d_count", k), W'(s_count), W'(tbl[k].e_count));
         cmp($sformatf("tbl%0d_nack", k),  W'(s_nack),  W'(tbl[k].e_nack));
      end
      cmp("tbl_out_cnt", dut_out.size(), 4);
      if (dut_out.size() == 4) begin
         cmp("tbl_out0", dut_out[0], 32'h11);
         cmp("tbl_out3", dut_out[3], 32'hA5);
      end

      // Fill to DEPTH under Nack; fifth word is refused and retried.
      dut_out.delete();
      w.delete();
      for (int k = 0; k < 5; k++) w.push_back(32'h100 + k);
      i = 0;
      while (i < 4) begin
         cycle(1'b1, 1'b1, w[i], 1'b1, 1'b0);
         if (!s_nack) i++;
      end
      cycle(1'b1, 1'b1, w[4], 1'b1, 1'b0);
      cmp("full_nack", W'(s_nack), 1);
      cmp("full_count", W'(s_count), 4);
      cycle(1'b1, 1'b1, w[4], 1'b0, 1'b0);
      cmp("full_nack_on_deq", W'(s_nack), 1);
      cycle(1'b1, 1'b1, w[4], 1'b0, 1'b0);
      cmp("full_nack_freed", W'(s_nack), 0);
      budget = 0;
      while (dut_out.size() < 5 && budget < 40) begin
         cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
         budget++;
      end
      cmp("full_out_cnt", dut_out.size(), 5);
      for (int k = 0; k < 5 && k < dut_out.size(); k++)
         cmp($sformatf("full_out%0d", k), dut_out[k], w[k]);

      // Pointer wrap: twelve words with random downstream Nacks.
      dut_out.delete();
      w.delete();
      for (int k = 0; k < 12; k++) w.push_back(32'h200 + k);
      i = 0;
      budget = 0;
      while (dut_out.size() < 12 && budget < 400) begin
         cycle(1'b1, i < 12, (i < 12) ? w[i] : '0, $urandom_range(0, 2) == 0, 1'b0);
         if (i < 12 && !s_nack) i++;
         budget++;
      end
      cmp("wrap_out_cnt", dut_out.size(), 12);
      for (int k = 0; k < 12 && k < dut_out.size(); k++)
         cmp($sformatf("wrap_out%0d", k), dut_out[k], w[k]);

      // Stall after NACK_LIMIT consecutive Nacked cycles, cleared after acceptance.
      cycle(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
         st[k] = s_stall;
         cmp($sformatf("stall_data%0d", k), s_data, 32'h55);
      end
      cmp("stall_before_limit", W'(st[8]), 0);
      cmp("stall_rise", W'(st[9]), 1);
      cmp("stall_held", W'(st[10]), 1);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cmp("stall_on_accept", W'(s_stall), 1);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cmp("stall_cleared", W'(s_stall), 0);

      // Release at occupancy 3 drops the concurrent word.
      cycle(1'b1, 1'b1, 32'h61, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 32'h62, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 32'h63, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 32'h64, 1'b0, 1'b1);
      cmp("rls_pre_count", W'(s_count), 3);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cmp("rls_count", W'(s_count), 0);
      cmp("rls_valid", W'(s_valid), 0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cmp("rls_dropped", W'(s_valid), 0);

      // Asynchronous reset mid-stream at occupancy 2.
      cycle(1'b1, 1'b1, 32'h71, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 32'h72, 1'b1, 1'b0);
      I_Valid = 1'b0;
      reset = 1'b1;
      #1;
      cmp("arst_valid", W'(O_Valid), 0);
      cmp("arst_data",  O_Data, 0);
      cmp("arst_count", W'(O_Count), 0);
      cmp("arst_nack",  W'(O_Nack), 0);
      q.delete();
      streak = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;

      // I_Active low freezes the queue.
      cycle(1'b1, 1'b1, 32'h81, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 32'h82, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 32'h83, 1'b0, 1'b0);
         cmp("inact_nack",  W'(s_nack), 1);
         cmp("inact_valid", W'(s_valid), 0);
         cmp("inact_count", W'(s_count), 2);
      end
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cmp("inact_resume", s_data, 32'h81);

      // Randomized traffic against the queue model; alternate phases of heavy Nack.
      for (int c = 0; c < 1500; c++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom,
               ((c / 64) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
               $urandom_range(0, 79) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
